lc3_ddr_uart_tx: RTL and testbench

Display-side consumer of the LC-3 memory-mapped display interface, the device end of the DDR/DSR register pair. When the CPU stores to DDR, the block captures the low byte, drops the DSR ready bit, and shifts the character out as an 8N1 serial frame. When the stop bit completes, it raises DSR ready again. It sits beside the datapath, driven by the address-control DDR load strobe and the MDR value, and feeds its status word back as the datapath's `output_dsr`.

---
 rtl/lc3_ddr_uart_tx_if.sv | 20 ++
 rtl/lc3_ddr_uart_tx.sv | 114 +++++++++++
 tb/tb_lc3_ddr_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lc3_ddr_uart_tx_if.sv
// Display-register bus between the LC-3 datapath (master) and the DDR/DSR
// serial display device (slave).
interface lc3_ddr_uart_tx_if;
  logic        i_LD_DDR;
  logic [15:0] i_ddr_data;
  logic [15:0] o_dsr;
  logic        o_tx;
  logic        o_busy;
  logic        o_overrun;

  modport master (
    output i_LD_DDR, i_ddr_data,
    input  o_dsr, o_tx, o_busy, o_overrun
  );

  modport slave (
    input  i_LD_DDR, i_ddr_data,
    output o_dsr, o_tx, o_busy, o_overrun
  );
endinterface

// File: rtl/lc3_ddr_uart_tx.sv
// LC-3 display device: a DDR store launches an 8N1 frame of the low byte;
// DSR[15] reports ready again once the stop bit has fully elapsed.
module lc3_ddr_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic               i_Clk,
  input logic               i_Reset,
  lc3_ddr_uart_tx_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx, tx_n;
  logic             ready, ready_n;
  logic             overrun, overrun_n;
  logic             bit_done;
  logic             unused_hi;

  // Only the low byte is a character; the upper byte is deliberately dropped.
  assign unused_hi = ^bus.i_ddr_data[15:8];
  assign bit_done  = (cnt == CNT_MAX);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    overrun_n = overrun;
    tx_n      = 1'b1;

    case (state)
      IDLE: begin
        if (bus.i_LD_DDR) begin
          shift_n   = bus.i_ddr_data[7:0];
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n     = '0;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A write while busy (including the edge that returns to IDLE) is dropped.
    if (bus.i_LD_DDR && (state != IDLE)) overrun_n = 1'b1;

    // Line level is derived from the next state so o_tx is a plain register.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase

    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      ready   <= ready_n;
      overrun <= overrun_n;
    end
  end

  assign bus.o_tx      = tx;
  assign bus.o_dsr     = {ready, 15'b0};
  assign bus.o_busy    = ~ready;
  assign bus.o_overrun = overrun;

endmodule

// File: tb/tb_lc3_ddr_uart_tx.sv
// Bench for lc3_ddr_uart_tx: two instances (4 and 2 clocks per bit) checked
// cycle by cycle against an ideal 8N1 frame model.
module tb_lc3_ddr_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc3_ddr_uart_tx_if b4 ();
  lc3_ddr_uart_tx_if b2 ();

  lc3_ddr_uart_tx #(.CLKS_PER_BIT(4)) dut4 (.i_Clk(clk), .i_Reset(rst), .bus(b4));
  lc3_ddr_uart_tx #(.CLKS_PER_BIT(2)) dut2 (.i_Clk(clk), .i_Reset(rst), .bus(b2));

  int tests  = 0;
  int failed = 0;
  int cur_sel = 0;
  logic ovr_model [2];

  logic        tx_s, busy_s, ovr_s;
  logic [15:0] dsr_s;

  always_comb begin
    if (cur_sel == 1) begin
      tx_s = b2.o_tx; busy_s = b2.o_busy; ovr_s = b2.o_overrun; dsr_s = b2.o_dsr;
    end else begin
      tx_s = b4.o_tx; busy_s = b4.o_busy; ovr_s = b4.o_overrun; dsr_s = b4.o_dsr;
    end
  end

  typedef struct {
    int          sel;
    logic [15:0] ddr;
    logic [9:0]  frame;
    int          ovr_at;
    logic        exp_ovr;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic ld, input logic [15:0] d);
    if (sel == 1) begin
      b2.i_LD_DDR = ld; b2.i_ddr_data = d;
    end else begin
      b4.i_LD_DDR = ld; b4.i_ddr_data = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes DDR now, then follows the whole frame: bit j/C of the frame on
  // the line for each of the 10C busy cycles, with an optional extra write.
  task automatic send(input int sel, input logic [15:0] d, input logic [9:0] frame,
                      input int ovr_at, input logic [15:0] junk, input logic exp_ovr);
    int c;
    int errs;
    int first_bad;
    c = (sel == 1) ? 2 : 4;
    errs = 0;
    first_bad = -1;
    cur_sel = sel;
    drive(sel, 1'b1, d);
    tick();
    drive(sel, 1'b0, 16'h0000);
    for (int j = 0; j < 10 * c; j++) begin
      if (tx_s !== frame[j / c] || dsr_s !== 16'h0000 || busy_s !== 1'b1) begin
        errs++;
        if (first_bad < 0) first_bad = j;
      end
      if (j == ovr_at) drive(sel, 1'b1, junk);
      tick();
      drive(sel, 1'b0, 16'h0000);
    end
    check($sformatf("frame C=%0d data=%h bad cycles (first %0d)", c, d[7:0], first_bad),
          errs, 0);
    check($sformatf("ready after frame C=%0d", c), dsr_s, 16'h8000);
    check($sformatf("line idle after frame C=%0d", c), {busy_s, tx_s}, 2'b01);
    check($sformatf("overrun after frame C=%0d", c), ovr_s, exp_ovr);
  endtask

  task automatic idle_check(input int sel, input int n);
    int errs;
    errs = 0;
    cur_sel = sel;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_s !== 1'b1 || dsr_s !== 16'h8000 || busy_s !== 1'b0) errs++;
    end
    if (n > 0) check($sformatf("idle %0d cycles sel=%0d bad", n, sel), errs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int c;
    int oa;
    logic [15:0] d;

    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    tbl[0] = '{0, 16'h1241, 10'h282, -1, 1'b0};
    tbl[1] = '{0, 16'hFF55, 10'h2AA, 11, 1'b1};
    tbl[2] = '{0, 16'h00AA, 10'h354, 39, 1'b1};
    tbl[3] = '{0, 16'h0000, 10'h200, -1, 1'b1};
    tbl[4] = '{1, 16'hABFF, 10'h3FE, -1, 1'b0};
    tbl[5] = '{1, 16'h0000, 10'h200, -1, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cur_sel = k;
      #0;
      check($sformatf("reset tx sel=%0d", k), tx_s, 1'b1);
      check($sformatf("reset dsr sel=%0d", k), dsr_s, 16'h8000);
      check($sformatf("reset busy sel=%0d", k), busy_s, 1'b0);
      check($sformatf("reset overrun sel=%0d", k), ovr_s, 1'b0);
    end
    idle_check(0, 50);

    for (int i = 0; i < 6; i++)
      send(tbl[i].sel, tbl[i].ddr, tbl[i].frame, tbl[i].ovr_at,
           tbl[i].ddr ^ 16'h00FF, tbl[i].exp_ovr);
    idle_check(0, 20);
    idle_check(1, 5);

    // Reset asserted during data bit 3 aborts the frame immediately.
    cur_sel = 0;
    drive(0, 1'b1, 16'h0033);
    tick();
    drive(0, 1'b0, 16'h0000);
    repeat (17) tick();
    check("busy before mid-frame reset", busy_s, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tx after mid-frame reset", tx_s, 1'b1);
    check("dsr after mid-frame reset", dsr_s, 16'h8000);
    check("overrun cleared by reset", ovr_s, 1'b0);
    send(0, 16'h000F, 10'h21E, -1, 16'h0000, 1'b0);

    // Reset takes priority over a simultaneous DDR write.
    rst = 1'b1;
    drive(0, 1'b1, 16'h0041);
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 16'h0000);
    check("dsr reset vs write", dsr_s, 16'h8000);
    tick();
    check("no frame after reset vs write", {busy_s, tx_s}, 2'b01);

    ovr_model[0] = 1'b0;
    ovr_model[1] = 1'b0;
    for (int r = 0; r < 12; r++) begin
      s = int'($urandom_range(0, 1));
      c = (s == 1) ? 2 : 4;
      d = 16'($urandom);
      oa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10 * c - 1)) : -1;
      if (oa >= 0) ovr_model[s] = 1'b1;
      send(s, d, {1'b1, d[7:0], 1'b0}, oa, d ^ 16'h00FF, ovr_model[s]);
      idle_check(s, int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
